axi_stream_packet_arbiter: RTL and testbench

- Packet-level round-robin arbiter in front of a shared packet FIFO (axi_stream_packet_long_fifo).
- Merges NUM AXI-Stream requesters onto one stream and grants whole packets only.
- Tags each packet with its source index on m_tdest.
- Guards the FIFO against over-long packets: forces tlast at MAX_BEATS and discards the rest of that input packet.

---
 rtl/axi_stream_packet_arbiter.sv | 158 +++++++++++++++
 tb/tb_axi_stream_packet_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-level round-robin arbiter: merges NUM AXI-Stream sources, grants whole packets,
// tags each with its source on m_tdest and truncates packets longer than MAX_BEATS.
module axi_stream_packet_arbiter #(
    parameter  int NUM       = 4,
    parameter  int DSIZE     = 32,
    parameter  int MAX_BEATS = 8096,
    localparam int CW        = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM*DSIZE-1:0] s_tdata,
    input  logic [NUM-1:0]       s_tvalid,
    input  logic [NUM-1:0]       s_tlast,
    output logic [NUM-1:0]       s_tready,
    output logic [DSIZE-1:0]     m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [CW-1:0]        m_tdest,
    output logic                 overlong_err,
    output logic                 busy
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_grant;
    logic [CW-1:0]   r_prio_ptr;
    logic [BW-1:0]   r_beat_cnt;
    logic            r_overlong_err;
    logic            r_busy;

    logic [DSIZE-1:0] w_sel_data;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [CW-1:0]    w_arb_grant;
    logic [CW-1:0]    w_next_prio;
    logic             w_limit;
    logic             w_out_beat;

    // First requester found walking forward from ptr, wrapping modulo NUM.
    function automatic logic [CW-1:0] rr_pick(input logic [NUM-1:0] req,
                                              input logic [CW-1:0]  ptr);
        logic [CW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            idx = (int'(ptr) + k) % NUM;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
        return pick;
    endfunction

    assign w_arb_grant = rr_pick(s_tvalid, r_prio_ptr);
    assign w_next_prio = (r_grant == CW'(NUM - 1)) ? '0 : r_grant + CW'(1);
    assign w_limit     = (r_beat_cnt == BW'(MAX_BEATS - 1));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (r_grant == CW'(i)) begin
                w_sel_data  = s_tdata[i*DSIZE +: DSIZE];
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
            end
        end
    end

    assign w_out_beat = (r_state == ST_PASS) && w_sel_valid && m_tready;

    // Zero-latency data path; only the granted channel ever sees ready.
    always_comb begin
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        case (r_state)
            ST_PASS: begin
                m_tdata           = w_sel_data;
                m_tvalid          = w_sel_valid;
                m_tlast           = w_sel_last || w_limit;
                s_tready[r_grant] = m_tready;
            end
            ST_DROP: begin
                s_tready[r_grant] = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_prio_ptr     <= '0;
            r_beat_cnt     <= '0;
            r_overlong_err <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_overlong_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        r_grant    <= w_arb_grant;
                        r_beat_cnt <= '0;
                        r_state    <= ST_PASS;
                        r_busy     <= 1'b1;
                    end
                end
                ST_PASS: begin
                    if (w_out_beat) begin
                        r_beat_cnt <= r_beat_cnt + BW'(1);
                        if (w_sel_last) begin
                            r_prio_ptr <= w_next_prio;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end else if (w_limit) begin
                            // Truncation beat: tlast was forced, swallow the rest of the input packet.
                            r_overlong_err <= 1'b1;
                            r_state        <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_prio_ptr <= w_next_prio;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_tdest      = r_grant;
    assign overlong_err = r_overlong_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Scoreboard bench for axi_stream_packet_arbiter: per-channel source queues feed the DUT,
// expected output beats (dest, last, data) are queued up front and popped on each output beat.
module tb_axi_stream_packet_arbiter;

    localparam int NUM       = 4;
    localparam int DSIZE     = 32;
    localparam int MAX_BEATS = 16;
    localparam int CW        = 2;
    localparam int EW        = CW + 1 + DSIZE;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM*DSIZE-1:0] s_tdata;
    logic [NUM-1:0]       s_tvalid;
    logic [NUM-1:0]       s_tlast;
    logic [NUM-1:0]       s_tready;
    logic [DSIZE-1:0]     m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;
    logic [CW-1:0]        m_tdest;
    logic                 overlong_err;
    logic                 busy;

    always #5 clk = ~clk;

    axi_stream_packet_arbiter #(
        .NUM      (NUM),
        .DSIZE    (DSIZE),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .m_tdest     (m_tdest),
        .overlong_err(overlong_err),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int out_beats, err_pulses, gap_min, gap_max, gap_cnt;

    logic [DSIZE:0]  src_q [NUM][$];
    logic [EW-1:0]   exp_q [$];

    // Queue one source packet; the expected output is truncated at MAX_BEATS with tlast forced.
    task automatic add_pkt(input int ch, input int id, input int n);
        for (int b = 1; b <= n; b++) begin
            logic [DSIZE-1:0] d;
            d = {8'(ch), 8'(id), 16'(b)};
            src_q[ch].push_back({1'(b == n), d});
            if (b <= MAX_BEATS)
                exp_q.push_back({CW'(ch), 1'(b == n || b == MAX_BEATS), d});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM; i++)
            if (src_q[i].size() != 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic drive_inputs(input int mode);
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() != 0) begin
                s_tvalid[i]                = 1'b1;
                s_tlast[i]                 = src_q[i][0][DSIZE];
                s_tdata[i*DSIZE +: DSIZE]  = src_q[i][0][DSIZE-1:0];
            end
        end
        m_tready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
    endtask

    // Cycle loop: drive on negedge, sample 1ns later, pop sources/scoreboard on handshakes.
    task automatic run(input int mode, input int stop_beats, input int budget);
        logic prev_last;
        int   last_cyc;
        out_beats  = 0;
        err_pulses = 0;
        gap_min    = 1000;
        gap_max    = 0;
        gap_cnt    = 0;
        prev_last  = 1'b0;
        last_cyc   = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            cyc++;
            drive_inputs(mode);
            #1;
            if (overlong_err) err_pulses++;
            if (stop_beats == 0 && all_empty()) return;
            if (m_tvalid) begin
                checks++;
                if (s_tready !== (NUM'(m_tready) << m_tdest)) begin
                    failures++;
                    $display("FAIL ready_route s_tready=%b m_tready=%b dest=%0d", s_tready, m_tready, m_tdest);
                end
            end
            if (m_tvalid && m_tready) begin
                out_beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got dest=%0d last=%b data=%h expected none", m_tdest, m_tlast, m_tdata);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    if ({m_tdest, m_tlast, m_tdata} !== e) begin
                        failures++;
                        $display("FAIL out_beat got dest=%0d last=%b data=%h expected dest=%0d last=%b data=%h",
                                 m_tdest, m_tlast, m_tdata, e[EW-1 -: CW], e[DSIZE], e[DSIZE-1:0]);
                    end
                end
                if (prev_last) begin
                    gap_cnt++;
                    if (cyc - last_cyc < gap_min) gap_min = cyc - last_cyc;
                    if (cyc - last_cyc > gap_max) gap_max = cyc - last_cyc;
                end
                prev_last = m_tlast;
                last_cyc  = cyc;
            end
            for (int i = 0; i < NUM; i++)
                if (s_tvalid[i] && s_tready[i]) void'(src_q[i].pop_front());
            if (stop_beats != 0 && out_beats == stop_beats) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout after %0d cycles, beats=%0d pending_exp=%0d", budget, out_beats, exp_q.size());
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({s_tready, m_tvalid, m_tlast, m_tdata, m_tdest, overlong_err, busy} !== '0) begin
            failures++;
            $display("FAIL %s outputs s_tready=%b m_tvalid=%b m_tlast=%b m_tdata=%h m_tdest=%0d err=%b busy=%b expected all 0",
                     tag, s_tready, m_tvalid, m_tlast, m_tdata, m_tdest, overlong_err, busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int ch = 0; ch < NUM; ch++) add_pkt(ch, 0, 2);
        add_pkt(0, 1, 2);
        run(0, 0, 200);
        checks++;
        if (out_beats !== 10 || err_pulses !== 0) begin
            failures++;
            $display("FAIL rr_counts beats=%0d err=%0d expected beats=10 err=0", out_beats, err_pulses);
        end
    endtask

    task automatic test_single_source();
        for (int p = 0; p < 3; p++) add_pkt(2, p, 5);
        run(0, 0, 200);
        checks++;
        if (out_beats !== 15 || err_pulses !== 0) begin
            failures++;
            $display("FAIL single_counts beats=%0d err=%0d expected beats=15 err=0", out_beats, err_pulses);
        end
        checks++;
        if (gap_cnt !== 2 || gap_min !== 2 || gap_max !== 2) begin
            failures++;
            $display("FAIL single_gap cnt=%0d min=%0d max=%0d expected cnt=2 min=2 max=2", gap_cnt, gap_min, gap_max);
        end
    endtask

    task automatic test_backpressure();
        add_pkt(1, 0, 8);
        run(1, 0, 200);
        checks++;
        if (out_beats !== 8 || err_pulses !== 0) begin
            failures++;
            $display("FAIL bp_counts beats=%0d err=%0d expected beats=8 err=0", out_beats, err_pulses);
        end
    endtask

    task automatic test_exact_limit();
        add_pkt(3, 0, MAX_BEATS);
        run(0, 0, 200);
        checks++;
        if (out_beats !== MAX_BEATS || err_pulses !== 0) begin
            failures++;
            $display("FAIL limit_counts beats=%0d err=%0d expected beats=%0d err=0", out_beats, err_pulses, MAX_BEATS);
        end
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL limit_idle busy=%b m_tvalid=%b expected 0 0", busy, m_tvalid);
        end
    endtask

    task automatic test_overlong();
        add_pkt(1, 0, 20);
        add_pkt(2, 0, 2);
        add_pkt(3, 0, 2);
        run(0, 0, 300);
        checks++;
        if (out_beats !== MAX_BEATS + 4 || err_pulses !== 1) begin
            failures++;
            $display("FAIL overlong_counts beats=%0d err=%0d expected beats=%0d err=1", out_beats, err_pulses, MAX_BEATS + 4);
        end
    endtask

    task automatic test_async_reset();
        add_pkt(1, 1, 2);
        run(0, 0, 100);
        add_pkt(2, 1, 10);
        run(0, 3, 100);
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_packet busy=%b m_tvalid=%b expected 1 1", busy, m_tvalid);
        end
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        exp_q.delete();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        @(negedge clk);
        rst = 1'b0;
        add_pkt(0, 2, 2);
        add_pkt(2, 2, 2);
        run(0, 0, 100);
        checks++;
        if (out_beats !== 4) begin
            failures++;
            $display("FAIL post_reset_beats got=%0d expected=4", out_beats);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_backpressure();
        test_exact_limit();
        test_overlong();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
